multu_seq: RTL and testbench
============================

Name: multu_seq

Overview:
- Iterative shift-add unsigned multiplier; the multiply counterpart of the team's sequential divider in the MIPS54 datapath.
- Serves MULTU (and, optionally, MULT): 32x32 operands produce a 64-bit product written to HI/LO.
- Same start/busy handshake style as the divider, so the CPU stall logic treats both units identically.
- Fully synchronous on the rising edge, one partial-product step per cycle.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH bits.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- multiplicand  in  WIDTH  operand A (rs).
- multiplier  in  WIDTH  operand B (rt).
- signed_op  in  1  present only with MULTU_SIGNED_EN; 1 = MULT semantics.
- hi  out  WIDTH  upper half of the last completed product.
- lo  out  WIDTH  lower half of the last completed product.
- busy  out  1  operation in progress; the CPU stalls on it.
- done  out  1  one-cycle pulse when hi/lo update.

Behaviour:
- Reset is asynchronous, active-high. It forces state=IDLE, hi=0, lo=0, busy=0, done=0, count=0, accumulator=0.
- Reset mid-operation aborts the multiply. No result is written, and hi/lo read 0.
- States: IDLE, RUN, and NEG (NEG exists only with the macro).
- IDLE + start=1 at edge k:
  - latch mcand=multiplicand and acc={1'b0, WIDTH'b0, multiplier} (2*WIDTH+1 bits);
  - set count=WIDTH, busy=1, state=RUN.
- RUN, each edge:
  - if acc[0]=1, acc[2W:W] = acc[2W-1:W] + mcand (the carry goes to bit 2W);
  - then acc shifts right logically by 1, and count decrements.
- The edge on which count reaches 0 is edge k+WIDTH. On that edge:
  - {hi,lo} <= final acc[2W-1:0];
  - done=1, busy=0, state=IDLE.
- Unsigned latency: busy is high for exactly WIDTH cycles (32); done is high in cycle k+WIDTH+1 only.
- hi/lo hold the previous result during RUN. They change only on completion.
- start while busy=1 is ignored: operands are not re-latched and nothing is queued.
- start in the cycle where done=1 (state IDLE) is accepted normally. done still deasserts after one cycle.
- Operand inputs may change freely after the start edge.
- Zero operand: still takes the full WIDTH cycles (no early exit); result 0.
- Arithmetic is modulo 2^(2W). The intermediate add is W+1 bits wide, so no carry is lost.

Optional Feature:
- Macro: MULTU_SIGNED_EN.
- With the macro, the signed_op port exists. When signed_op=1 at start:
  - each operand is replaced by its magnitude (two's-complement negate if the MSB is set; 0x80000000 stays 0x80000000 as unsigned);
  - neg_flag = multiplicand[W-1] XOR multiplier[W-1];
  - after RUN the FSM always enters NEG for one cycle: {hi,lo} = neg_flag ? -acc : acc;
  - done pulses one cycle later, so busy lasts W+1 cycles.
- With the macro and signed_op=0, timing is identical to the unsigned path.
- Without the macro: no signed_op port, no NEG state, and behaviour is exactly the unsigned description above.

Decomposition:
- Shared package mul_pkg holds:
  - MUL_WIDTH default constant (32);
  - state typedef mul_state_t {IDLE, RUN, NEG};
  - count width constant $clog2(MUL_WIDTH+1).
- No sub-module is required. The two's-complement negate for MULTU_SIGNED_EN is a local function, not a separate module.

Test Plan:
- 3 x 5, start at cycle 0 -> busy high cycles 1-32, done pulse cycle 33, hi=0x00000000, lo=0x0000000F.
- 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; intermediate carry not lost.
- 0x12345678 x 0x9ABCDEF0 started; start reasserted with 1 x 1 on cycle 10 -> ignored; result hi=0x0B00EA4E, lo=0x242D2080 at cycle 33.
- Prior result 3 x 5 held, then 7 x 9 started, reset pulsed at cycle 16 -> hi=lo=0, busy=0 immediately; no done pulse; next start 7 x 9 yields lo=0x3F.
- Back-to-back: start 2 x 2 accepted in the done cycle of a prior op -> second done 32 cycles later, lo=0x4; hi/lo keep the first result until then.
- MULTU_SIGNED_EN, signed_op=1:
  - -3 (0xFFFFFFFD) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy 33 cycles;
  - 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier.
// Holds the default width, the count width and the FSM state type.
package mul_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int MUL_CNT_W = $clog2(MUL_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        NEG
    } mul_state_t;

endpackage

// File: rtl/multu_seq.sv
// Iterative shift-add multiplier for MULTU (and MULT with MULTU_SIGNED_EN).
// Ports: clock, reset (async, active-high), start, multiplicand, multiplier,
//        signed_op (only with MULTU_SIGNED_EN), hi, lo, busy, done.
// One partial-product step per cycle; hi/lo change only on completion.
import mul_pkg::*;

module multu_seq #(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
`ifdef MULTU_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    mul_state_t         r_state;
    mul_state_t         w_next_state;
    logic [2*WIDTH:0]   r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH:0]   w_step;
    logic               w_last;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_to_neg;

`ifdef MULTU_SIGNED_EN
    logic               r_sgn;
    logic               r_neg;

    function automatic logic [WIDTH-1:0] f_mag(
        input logic [WIDTH-1:0] x
    );
        return x[WIDTH-1] ? -x : x;
    endfunction

    assign w_a_mag  = signed_op ? f_mag(multiplicand) : multiplicand;
    assign w_b_mag  = signed_op ? f_mag(multiplier) : multiplier;
    assign w_to_neg = r_sgn;
`else
    assign w_a_mag  = multiplicand;
    assign w_b_mag  = multiplier;
    assign w_to_neg = 1'b0;
`endif

    // W+1-bit add keeps the carry, which lands in acc[2W] before the shift.
    assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
    assign w_step = r_acc[0] ? {1'b0, w_sum, r_acc[WIDTH-1:1]}
                             : {1'b0, r_acc[2*WIDTH:1]};
    assign w_last = (r_count == CW'(1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next_state = w_to_neg ? NEG : IDLE;
                end
            end
            NEG: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc   <= '0;
            r_mcand <= '0;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef MULTU_SIGNED_EN
            r_sgn   <= 1'b0;
            r_neg   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcand <= w_a_mag;
                        r_acc   <= {1'b0, {WIDTH{1'b0}}, w_b_mag};
                        r_count <= CW'(WIDTH);
                        r_busy  <= 1'b1;
`ifdef MULTU_SIGNED_EN
                        r_sgn   <= signed_op;
                        r_neg   <= signed_op &
                                   (multiplicand[WIDTH-1] ^
                                    multiplier[WIDTH-1]);
`endif
                    end
                end
                RUN: begin
                    r_acc   <= w_step;
                    r_count <= r_count - 1'b1;
                    if (w_last && !w_to_neg) begin
                        {r_hi, r_lo} <= w_step[2*WIDTH-1:0];
                        r_done       <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
`ifdef MULTU_SIGNED_EN
                NEG: begin
                    {r_hi, r_lo} <= r_neg ? -r_acc[2*WIDTH-1:0]
                                          : r_acc[2*WIDTH-1:0];
                    r_done       <= 1'b1;
                    r_busy       <= 1'b0;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_multu_seq.sv
// Self-checking bench for multu_seq: directed cases plus random operands
// compared against a plain-arithmetic product model.
module tb_multu_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
`ifdef MULTU_SIGNED_EN
    logic        signed_op;
`endif

    int checks = 0;
    int errors = 0;

    multu_seq #(.WIDTH(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
`ifdef MULTU_SIGNED_EN
        .signed_op    (signed_op),
`endif
        .hi           (hi),
        .lo           (lo),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic s);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = {{32{s & a[31]}}, a};
        eb = {{32{s & b[31]}}, b};
        return ea * eb;
    endfunction

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic s);
        multiplicand = a;
        multiplier   = b;
`ifdef MULTU_SIGNED_EN
        signed_op    = s;
`else
        if (s) $display("note: signed op requested in unsigned build");
`endif
        start = 1'b1;
        tick();
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
    endtask

    task automatic wait_done(output int nbusy, output bit to);
        nbusy = 0;
        while (busy && nbusy < 200) begin
            nbusy++;
            tick();
        end
        to = busy;
    endtask

    task automatic check_op(input string nm, input logic [31:0] a,
                            input logic [31:0] b, input logic s);
        int          n;
        bit          to;
        logic [63:0] exp;
        int          lat;
        exp = model(a, b, s);
        lat = s ? 33 : 32;
        start_op(a, b, s);
        wait_done(n, to);
        checks++;
        if (to || n !== lat) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", nm, n, lat);
        end
        checks++;
        if (done !== 1'b1 || {hi, lo} !== exp) begin
            errors++;
            $display("FAIL %s result done=%b got %h want %h",
                     nm, done, {hi, lo}, exp);
        end
        tick();
        checks++;
        if (done !== 1'b0 || {hi, lo} !== exp) begin
            errors++;
            $display("FAIL %s hold done=%b got %h want %h",
                     nm, done, {hi, lo}, exp);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        multiplicand = '0;
        multiplier = '0;
`ifdef MULTU_SIGNED_EN
        signed_op = 1'b0;
`endif
        tick();
        checks++;
        if ({hi, lo, busy, done} !== 66'b0) begin
            errors++;
            $display("FAIL reset got %h %h %b %b want 0", hi, lo, busy, done);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        check_op("3x5", 32'd3, 32'd5, 1'b0);
        checks++;
        if (lo !== 32'h0000000F || hi !== 32'h0) begin
            errors++;
            $display("FAIL 3x5 const got %h %h want 0 f", hi, lo);
        end
        check_op("ffxff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        checks++;
        if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            errors++;
            $display("FAIL ffxff const got %h %h want fffffffe 1", hi, lo);
        end
        check_op("zero", 32'h0, 32'hDEADBEEF, 1'b0);
    endtask

    task automatic test_ignore_start;
        int          n = 0;
        int          m;
        bit          to;
        logic [63:0] exp;
        exp = model(32'h12345678, 32'h9ABCDEF0, 1'b0);
        start_op(32'h12345678, 32'h9ABCDEF0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            if (busy) n++;
            tick();
        end
        multiplicand = 32'd1;
        multiplier   = 32'd1;
        start = 1'b1;
        if (busy) n++;
        tick();
        start = 1'b0;
        wait_done(m, to);
        checks++;
        if (to || n + m !== 32) begin
            errors++;
            $display("FAIL ignore latency got %0d want 32", n + m);
        end
        checks++;
        if (done !== 1'b1 || {hi, lo} !== exp) begin
            errors++;
            $display("FAIL ignore result got %h want %h", {hi, lo}, exp);
        end
        tick();
    endtask

    task automatic test_reset_abort;
        int ndone = 0;
        int nbusy = 0;
        check_op("pre", 32'd3, 32'd5, 1'b0);
        start_op(32'd7, 32'd9, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        reset = 1'b1;
        #1;
        checks++;
        if ({hi, lo, busy, done} !== 66'b0) begin
            errors++;
            $display("FAIL abort got %h %h %b %b want 0", hi, lo, busy, done);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) ndone++;
            if (busy) nbusy++;
        end
        checks++;
        if (ndone !== 0 || nbusy !== 0) begin
            errors++;
            $display("FAIL abort quiet done=%0d busy=%0d want 0 0",
                     ndone, nbusy);
        end
        check_op("7x9", 32'd7, 32'd9, 1'b0);
        checks++;
        if (lo !== 32'h3F) begin
            errors++;
            $display("FAIL 7x9 const got %h want 3f", lo);
        end
    endtask

    task automatic test_back_to_back;
        int          n;
        bit          to;
        int          bad = 0;
        logic [63:0] first;
        first = model(32'hCAFEF00D, 32'h0BADBEEF, 1'b0);
        start_op(32'hCAFEF00D, 32'h0BADBEEF, 1'b0);
        wait_done(n, to);
        checks++;
        if (to || done !== 1'b1 || {hi, lo} !== first) begin
            errors++;
            $display("FAIL b2b first got %h want %h", {hi, lo}, first);
        end
        start_op(32'd2, 32'd2, 1'b0);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b accept done=%b busy=%b want 0 1", done, busy);
        end
        n = 0;
        while (busy && n < 200) begin
            if ({hi, lo} !== first) bad++;
            n++;
            tick();
        end
        checks++;
        if (bad !== 0 || n !== 32) begin
            errors++;
            $display("FAIL b2b hold bad=%0d lat=%0d want 0 32", bad, n);
        end
        checks++;
        if (done !== 1'b1 || {hi, lo} !== 64'd4) begin
            errors++;
            $display("FAIL b2b second got %h want 4", {hi, lo});
        end
        tick();
    endtask

    task automatic test_random;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = $urandom;
            if (i == 3) a = '0;
            if (i == 4) b = '0;
            if (i == 5) b = 32'h80000000;
            check_op("rand", a, b, 1'b0);
        end
    endtask

`ifdef MULTU_SIGNED_EN
    task automatic test_signed;
        check_op("s-3x7", 32'hFFFFFFFD, 32'd7, 1'b1);
        checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
            errors++;
            $display("FAIL s-3x7 const got %h %h", hi, lo);
        end
        check_op("s8x8", 32'h80000000, 32'h80000000, 1'b1);
        checks++;
        if (hi !== 32'h40000000 || lo !== 32'h0) begin
            errors++;
            $display("FAIL s8x8 const got %h %h", hi, lo);
        end
        for (int i = 0; i < 12; i++) begin
            check_op("srand", $urandom, $urandom, 1'b1);
            check_op("urand", $urandom, $urandom, 1'b0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
`ifdef MULTU_SIGNED_EN
        test_signed();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
